// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the zero-register index and legacy bus macros kept for older call sites.
`ifndef REGFILE_MP_PKG_MACROS
`define REGFILE_MP_PKG_MACROS
`define RegDataBus 31:0
`define RegAddrBus 4:0
`define REG_NUM    32
`define REG_ZERO   0
`endif

package regfile_mp_pkg;

    localparam int REG_DATA_W   = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_ZERO_IDX = 0;

    function automatic int reg_num(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Reduces all write ports to a single (hit, data) pair for one address;
// the highest-index matching port wins, and the zero register never hits.
module regfile_wr_arb
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]        addr_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        data_o
);

    logic addr_ok;

    assign addr_ok = (ZERO_REG == 0) || (addr_i != ADDR_W'(REG_ZERO_IDX));

    // Later iterations overwrite earlier ones, giving higher port indices priority.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (addr_ok && wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[p*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with enable-qualified write bypass, optional
// registered read path and a per-register busy scoreboard for RAW detection.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int RD_REG   = 0,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    input  logic                     flush_i,
    output logic [2**ADDR_W-1:0]     busy_vec_o
);

    localparam int DEPTH = reg_num(ADDR_W);

    logic [DATA_W-1:0] mem_q     [DEPTH];
    logic [DATA_W-1:0] mem_d     [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [DEPTH-1:0]  ent_hit;
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [ADDR_W-1:0] rd_addr   [NUM_RD];
    logic [DATA_W-1:0] rd_byp    [NUM_RD];
    logic [DATA_W-1:0] rd_comb   [NUM_RD];
    logic [DATA_W-1:0] rd_data_q [NUM_RD];
    logic [DATA_W-1:0] rd_data_d [NUM_RD];
    logic [NUM_RD-1:0] rd_hit;

    // One arbiter per entry decodes the write; one per read port drives the bypass.
    for (genvar a = 0; a < DEPTH; a++) begin : g_ent
        regfile_wr_arb #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_arb (
            .addr_i    (ADDR_W'(a)),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .hit_o     (ent_hit[a]),
            .data_o    (ent_data[a])
        );
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign rd_addr[k] = rd_addr_i[k*ADDR_W +: ADDR_W];

        regfile_wr_arb #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_arb (
            .addr_i    (rd_addr[k]),
            .wr_en_i   (wr_en_i),
            .wr_addr_i (wr_addr_i),
            .wr_data_i (wr_data_i),
            .hit_o     (rd_hit[k]),
            .data_o    (rd_byp[k])
        );
    end

    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = ent_hit[a] ? ent_data[a] : mem_q[a];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= mem_d[a];
            end
        end
    end

    // Busy status masks a same-cycle writeback so it agrees with the bypassed data.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_hit[k]) begin
                rd_comb[k] = rd_byp[k];
            end else if ((ZERO_REG != 0) && (rd_addr[k] == ADDR_W'(REG_ZERO_IDX))) begin
                rd_comb[k] = '0;
            end else begin
                rd_comb[k] = mem_q[rd_addr[k]];
            end
            rd_busy_o[k]                 = busy_q[rd_addr[k]] & ~rd_hit[k];
            rd_data_d[k]                 = rd_en_i[k] ? rd_comb[k] : rd_data_q[k];
            rd_data_o[k*DATA_W +: DATA_W] = (RD_REG != 0) ? rd_data_q[k] : rd_comb[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data_q[k] <= rd_data_d[k];
            end
        end
    end

    // Reservation outranks a same-cycle writeback: the new producer owns the register.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (rsv_en_i && (rsv_addr_i == ADDR_W'(a)) &&
                    !((ZERO_REG != 0) && (a == REG_ZERO_IDX))) begin
                    busy_d[a] = 1'b1;
                end else if (ent_hit[a]) begin
                    busy_d[a] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a combinational-read and a registered-read instance from shared stimulus
// and checks both against an array-based reference model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              flush;

    logic [NR*DW-1:0]  rd_data_c, rd_data_r;
    logic [NR-1:0]     rd_busy_c, rd_busy_r;
    logic [DEPTH-1:0]  busy_vec_c, busy_vec_r;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] mdl   [DEPTH];
    logic          mbusy [DEPTH];
    logic [DW-1:0] mreg  [NR];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .RD_REG(0), .ZERO_REG(1)) u_comb (
        .clk(clk), .rst_n(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_c),
        .rd_busy_o(rd_busy_c), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_vec_c)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .RD_REG(1), .ZERO_REG(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_r),
        .rd_busy_o(rd_busy_r), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_vec_o(busy_vec_r)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: search write ports from the highest index down, first match wins.
    function automatic void eff(input int a, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        for (int p = NW - 1; p >= 0; p--) begin
            if (!h && wr_en[p] && int'(wr_addr[p*AW +: AW]) == a && a != 0) begin
                h = 1'b1;
                d = wr_data[p*DW +: DW];
            end
        end
    endfunction

    function automatic logic [DW-1:0] read_val(input int a);
        logic          h;
        logic [DW-1:0] d;
        eff(a, h, d);
        if (h) return d;
        if (a == 0) return '0;
        return mdl[a];
    endfunction

    function automatic logic read_busy(input int a);
        logic          h;
        logic [DW-1:0] d;
        eff(a, h, d);
        return mbusy[a] && !h;
    endfunction

    function automatic logic [DEPTH-1:0] busy_vec_exp();
        logic [DEPTH-1:0] v;
        for (int a = 0; a < DEPTH; a++) v[a] = mbusy[a];
        return v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            mdl[a]   = '0;
            mbusy[a] = 1'b0;
        end
        for (int k = 0; k < NR; k++) mreg[k] = '0;
    endtask

    task automatic idle();
        rd_en    = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    // Checks combinational outputs mid-cycle while inputs are stable.
    task automatic applyStimulus();
        @(negedge clk);
        for (int k = 0; k < NR; k++) begin
            int a;
            a = int'(rd_addr[k*AW +: AW]);
            check($sformatf("comb_rd%0d_data", k), rd_data_c[k*DW +: DW], read_val(a));
            check($sformatf("comb_rd%0d_busy", k), DW'(rd_busy_c[k]), DW'(read_busy(a)));
            check($sformatf("reg_rd%0d_busy", k), DW'(rd_busy_r[k]), DW'(read_busy(a)));
        end
    endtask

    // Advances the model across the clock edge and checks registered outputs.
    task automatic checkOutput();
        logic [DW-1:0] nmem  [DEPTH];
        logic          nbusy [DEPTH];
        logic [DW-1:0] nreg  [NR];
        logic          h;
        logic [DW-1:0] d;
        for (int a = 0; a < DEPTH; a++) begin
            eff(a, h, d);
            nmem[a]  = h ? d : mdl[a];
            nbusy[a] = mbusy[a];
            if (flush) nbusy[a] = 1'b0;
            else if (rsv_en && int'(rsv_addr) == a && a != 0) nbusy[a] = 1'b1;
            else if (h) nbusy[a] = 1'b0;
        end
        for (int k = 0; k < NR; k++) begin
            nreg[k] = rd_en[k] ? read_val(int'(rd_addr[k*AW +: AW])) : mreg[k];
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            mdl[a]   = nmem[a];
            mbusy[a] = nbusy[a];
        end
        for (int k = 0; k < NR; k++) mreg[k] = nreg[k];
        check("busy_vec_comb", busy_vec_c, busy_vec_exp());
        check("busy_vec_reg", busy_vec_r, busy_vec_exp());
        for (int k = 0; k < NR; k++) begin
            check($sformatf("reg_rd%0d_data", k), rd_data_r[k*DW +: DW], mreg[k]);
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        model_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state: every address reads zero on both ports.
        check("reset_busy_vec", busy_vec_c, '0);
        rd_en = '1;
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            applyStimulus();
            check("reset_rd0", rd_data_c[DW-1:0], '0);
            check("reset_rd1", rd_data_c[2*DW-1:DW], '0);
            checkOutput();
        end

        // Asynchronous reset asserted during a write discards it.
        idle();
        set_wr(0, 5, 32'hDEAD);
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        idle();
        #2;
        rst_n = 1'b1;
        set_rd(0, 5);
        applyStimulus();
        check("midwrite_x5", rd_data_c[DW-1:0], '0);
        checkOutput();

        // Same-address write on both ports: port 1 wins, bypass shows it.
        idle();
        set_wr(0, 3, 32'h11);
        set_wr(1, 3, 32'h22);
        set_rd(0, 3);
        applyStimulus();
        check("bypass_x3", rd_data_c[DW-1:0], 32'h22);
        checkOutput();
        idle();
        applyStimulus();
        check("stored_x3", rd_data_c[DW-1:0], 32'h22);
        checkOutput();

        // Disabled write must not bypass; writes to x0 are dropped.
        set_wr(0, 7, 32'h5);
        applyStimulus();
        checkOutput();
        idle();
        wr_addr[AW-1:0] = AW'(7);
        wr_data[DW-1:0] = 32'hFFFF;
        set_rd(0, 7);
        applyStimulus();
        check("no_false_bypass_x7", rd_data_c[DW-1:0], 32'h5);
        checkOutput();
        idle();
        set_wr(0, 0, 32'h9);
        set_rd(1, 0);
        applyStimulus();
        check("x0_bypass_zero", rd_data_c[2*DW-1:DW], '0);
        checkOutput();
        idle();
        applyStimulus();
        check("x0_stored_zero", rd_data_c[2*DW-1:DW], '0);
        checkOutput();

        // Registered read: write-first capture, then hold when disabled.
        idle();
        rd_en[0] = 1'b1;
        set_rd(0, 4);
        set_wr(0, 4, 32'hAB);
        applyStimulus();
        checkOutput();
        check("regread_x4_ab", rd_data_r[DW-1:0], 32'hAB);
        idle();
        set_wr(1, 4, 32'hCD);
        applyStimulus();
        checkOutput();
        check("regread_hold_ab", rd_data_r[DW-1:0], 32'hAB);

        // Scoreboard: reserve, writeback, reserve-beats-writeback, x0 never busy.
        idle();
        rsv_en   = 1'b1;
        rsv_addr = AW'(9);
        applyStimulus();
        checkOutput();
        check("rsv_x9_busy", DW'(busy_vec_c[9]), 32'h1);
        idle();
        set_wr(0, 9, 32'h99);
        set_rd(0, 9);
        applyStimulus();
        check("wb_x9_rd_busy", DW'(rd_busy_c[0]), '0);
        checkOutput();
        check("wb_x9_cleared", DW'(busy_vec_c[9]), '0);
        idle();
        rsv_en   = 1'b1;
        rsv_addr = AW'(9);
        set_wr(1, 9, 32'h77);
        applyStimulus();
        checkOutput();
        check("rsv_wb_x9_busy", DW'(busy_vec_c[9]), 32'h1);
        idle();
        rsv_en   = 1'b1;
        rsv_addr = AW'(0);
        applyStimulus();
        checkOutput();
        check("rsv_x0_ignored", DW'(busy_vec_c[0]), '0);

        // Flush wins over a same-cycle reservation.
        for (int r = 2; r <= 4; r++) begin
            idle();
            rsv_en   = 1'b1;
            rsv_addr = AW'(r);
            applyStimulus();
            checkOutput();
        end
        idle();
        flush    = 1'b1;
        rsv_en   = 1'b1;
        rsv_addr = AW'(5);
        applyStimulus();
        checkOutput();
        check("flush_all_clear", busy_vec_c, '0);

        // Randomised traffic with a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 7 : DEPTH - 1;
            idle();
            rd_en    = NR'($urandom);
            for (int k = 0; k < NR; k++) set_rd(k, $urandom_range(0, lim));
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 2) != 0) set_wr(p, $urandom_range(0, lim), $urandom);
            end
            rsv_en   = $urandom_range(0, 1) == 1;
            rsv_addr = AW'($urandom_range(0, lim));
            flush    = $urandom_range(0, 15) == 0;
            applyStimulus();
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write-port integer register file.
- Configurable data width, depth, and numbers of read and write ports.
- Write-to-read bypass qualified by enable, with a selectable combinational or registered read path.
- Built-in per-register busy scoreboard (reserve at issue, clear at writeback, flush) so dual-issue and multi-cycle pipelines detect RAW hazards without an external table.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; port index is the priority order.
- RD_REG, 0, read mode: 0 = combinational read with bypass; 1 = registered read with 1-cycle latency.
- ZERO_REG, 1, 1 = entry 0 hardwired to zero and never busy; 0 = entry 0 is an ordinary register.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, reset: one clock; reset is asynchronous and active-low.
- rd_en_i, input, NUM_RD, read enable per port; used only when RD_REG=1.
- rd_addr_i, input, NUM_RD*ADDR_W, read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data_o, output, NUM_RD*DATA_W, read data, packed the same way as the addresses.
- rd_busy_o, output, NUM_RD, busy status of each addressed register.
- wr_en_i, input, NUM_WR, write enables.
- wr_addr_i, input, NUM_WR*ADDR_W, write addresses.
- wr_data_i, input, NUM_WR*DATA_W, write data.
- rsv_en_i, input, 1, reserve destination register (issue stage).
- rsv_addr_i, input, ADDR_W, register to reserve.
- flush_i, input, 1, clears every busy bit.
- busy_vec_o, output, 2**ADDR_W, full scoreboard, registered.

Behaviour:
- Reset (async, rst_n=0):
  - All registers = 0.
  - All busy bits = 0.
  - rd_data_o = 0 when RD_REG=1.
  - Reset mid-write discards that write.
- Write:
  - At the rising edge, each enabled port writes its address.
  - Several ports hitting one address: highest port index wins.
  - ZERO_REG=1: writes to address 0 are ignored.
- Effective write (same cycle), per address a:
  - Data from the highest-index port with wr_en=1, wr_addr=a, and a nonzero-or-ZERO_REG=0.
  - "hit" is true when such a port exists.
- Read, RD_REG=0:
  - rd_data_o[k] = effective write data if hit, else array[addr_k].
  - Purely combinational.
  - Address 0 reads 0 when ZERO_REG=1.
  - A bypass never fires when wr_en=0; this is the required fix over unqualified address compare.
- Read, RD_REG=1:
  - At the edge with rd_en_i[k]=1, rd_data_o[k] captures the same value the combinational path would produce that cycle (write-first).
  - With rd_en_i[k]=0, rd_data_o[k] holds.
  - Latency: exactly 1 cycle.
- Scoreboard next state, per entry a, in priority order:
  - flush_i=1 → 0, for all entries.
  - else rsv_en_i=1 and rsv_addr_i=a → 1. Reserve beats a same-cycle writeback: the new producer owns the register.
  - else any effective write to a → 0.
  - else hold.
  - ZERO_REG=1: entry 0 is never set.
- rd_busy_o[k]:
  - Combinational: busy[addr_k] & ~hit(addr_k).
  - A writeback in the same cycle therefore reads as not busy, consistent with the bypassed data.
  - Same-cycle reservations are not reflected until the next cycle.
  - In RD_REG=1 mode, rd_busy_o stays combinational; the consumer registers it if needed.
- busy_vec_o is driven directly from the busy flops.
- No X propagation: out-of-range conditions cannot occur since depth = 2**ADDR_W.

Decomposition:
- Shared header: default DATA_W/ADDR_W constants alongside the existing RegDataBus / RegAddrBus / REG_NUM macros, plus a macro for the zero-register index.
- One sub-module, regfile_wr_arb: given an address, reduces the NUM_WR write ports to (hit, data) by index priority.
  - Instantiated once per read port for bypass.
  - Used per array entry for the write decode.
- Scoreboard and array stay in the top module.

Test Plan:
- Reset then read all 32 addresses on both ports → 0; busy_vec_o = 0; assert rst_n low mid-write of 0xDEAD to x5 → x5 stays 0.
- Port0 writes 0x11 to x3 and port1 writes 0x22 to x3 in the same cycle → next-cycle read x3 = 0x22; same cycle with RD_REG=0 → rd_data = 0x22 bypassed.
- wr_addr=x7, wr_en=0, wr_data=0xFFFF with x7 holding 0x5 → read x7 = 0x5 (no false bypass); write 0x9 to x0 → x0 reads 0.
- RD_REG=1: rd_en=1 for addr x4 while writing 0xAB to x4 → rd_data_o = 0xAB one cycle later; rd_en=0 next cycle with x4 rewritten to 0xCD → output holds 0xAB.
- Scoreboard sequence:
  - Reserve x9 → busy_vec_o[9] = 1 next cycle.
  - Write x9 → rd_busy_o = 0 in that same cycle and busy clears.
  - Reserve plus write of x9 in one cycle → busy stays 1.
  - Reserve x0 → no effect.
- Reserve x2, x3, x4, then flush_i together with rsv_en of x5 → busy_vec_o = 0 (flush wins).
